izigzag_4x4_buffer: RTL and testbench
=====================================

Name: izigzag_4x4_buffer

Overview:
- Upstream neighbour of the dequantizer.
- Accepts quantized 4x4 residual coefficients in H.264 frame zigzag scan order, one per cycle, as produced by entropy decoding.
- Reorders each block into raster order (row-major, position = 4*row + col) through a ping-pong pair of 16-entry banks.
- Streams each reordered block to the dequantizer with its QP attached.
- Sustains 1 coefficient/cycle with no inter-block bubble.

Parameters:
COEF_W, 16, signed coefficient width in bits
QP_W, 6, quantization parameter width in bits

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_coef/in_qp valid this cycle
in_ready  output  1  block can accept an input this cycle
in_coef  input  COEF_W  signed coefficient, zigzag order
in_qp  input  QP_W  block QP; sampled only on the first coefficient (scan index 0) of a block
out_valid  output  1  out_* valid this cycle
out_ready  input  1  dequantizer accepts output this cycle
out_coef  output  COEF_W  coefficient, raster order
out_idx  output  4  raster position 0..15 of out_coef
out_qp  output  QP_W  QP of the block being drained
out_last  output  1  high with out_idx==15

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* holds stable while out_valid && !out_ready.
- Storage: two banks, each with 16 x COEF_W coefficient registers, a QP register, and a full flag.
- Write side:
  - State is wr_bank (1b) and wr_cnt (4b, the scan index).
  - On an input transfer, write in_coef to bank[wr_bank][ZZ[wr_cnt]], where ZZ = {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
  - When wr_cnt==0, also latch in_qp into that bank.
  - wr_cnt increments each transfer.
  - When wr_cnt==15: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- in_ready = !full[wr_bank] (combinational from registers; independent of in_valid).
- Read side:
  - State is rd_bank (1b) and rd_cnt (4b, the raster index).
  - out_valid = full[rd_bank].
  - out_coef = bank[rd_bank][rd_cnt]; out_idx = rd_cnt; out_qp = bank[rd_bank].qp; out_last = (rd_cnt==15).
  - On an output transfer, rd_cnt increments.
  - When rd_cnt==15: clear full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0.
- Latency: the first raster coefficient (idx 0) is presented with out_valid=1 on the cycle after the 16th input transfer.
- Gapless throughput:
  - With in_valid and out_ready held high, out_valid stays high continuously from cycle 16 onward.
  - The bank freed at the end of a drain becomes writable on the next cycle.
- Bank states:
  - Each bank cycles EMPTY -> FILLING (wr_cnt>0 on that bank) -> FULL -> DRAINING (rd_cnt>0) -> EMPTY.
  - The write and read sides never operate on the same bank in the same cycle unless that bank is the write target while not full. The ordering invariant guarantees this.
- Simultaneous events on different banks are independent:
  - A bank-fill completion and a bank-drain completion in the same cycle both take effect.
  - in_ready in the next cycle reflects the updated flags.
- Both banks full: in_ready=0. in_valid is ignored with no write and no counter change until a drain completes.
- Empty: out_valid=0 and out_coef is driven to 0. out_ready is ignored.
- Partial block: coefficients are held indefinitely with no timeout. Output starts only on a complete block.
- Reset, including mid-block or mid-drain:
  - Clears both full flags, wr_bank, wr_cnt, rd_bank and rd_cnt; partial data is discarded.
  - Output reset values: in_ready=1, out_valid=0, out_coef=0, out_idx=0, out_qp=0, out_last=0.
  - Coefficient storage is not reset.
- Arithmetic: none on data. Coefficients pass through bit-exact, sign preserved.

Test Plan:
1. Single block: inputs 0..15 (value = scan index), qp=28, out_ready=1 -> at cycle 16, outputs in raster order 0,1,5,6,2,4,7,12,3,8,11,13,9,10,14,15, out_qp=28, out_last only on the 16th output.
2. Back-to-back: 4 blocks with qp 10/20/30/40, in_valid and out_ready always 1 -> out_valid continuously high for 64 cycles from cycle 16; each block carries its own qp; in_ready never drops.
3. Backpressure: out_ready=0 while 3 blocks are offered -> in_ready drops after the 32nd accepted input and the 3rd block stalls. Raising out_ready resumes the stream with no loss and no duplication; outputs stay stable while stalled.
4. Random out_ready (50%) and random in_valid gaps, signed values including -32768 and 32767 -> scoreboard matches a reference permutation bit-exactly.
5. Reset mid-operation: assert reset after 7 inputs of block B while block A is at out_idx 9 -> next cycle out_valid=0 and in_ready=1. A fresh block afterwards comes out correctly, starting at idx 0.
6. qp sampling: change in_qp on scan indices 1..15 -> out_qp equals the value at index 0.

Source files
------------

// File: rtl/izigzag_4x4_buffer.sv
`timescale 1ns/1ps
// Purpose: reorders 4x4 H.264 zigzag-scan coefficients into raster order via two ping-pong banks, QP attached.
// Latency: raster index 0 is presented the cycle after the 16th input transfer of a block; 1 coef/cycle, gapless.
// Backpressure: in_ready drops while the write bank is still full; out_* hold stable while out_valid && !out_ready.
module izigzag_4x4_buffer #(
   parameter int COEF_W = 16,
   parameter int QP_W   = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [COEF_W-1:0] in_coef,
   input  logic [QP_W-1:0]          in_qp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [COEF_W-1:0] out_coef,
   output logic [3:0]               out_idx,
   output logic [QP_W-1:0]          out_qp,
   output logic                     out_last
);

   // Raster position of each zigzag scan index.
   function automatic logic [3:0] zz_pos(input logic [3:0] k);
      logic [3:0] p;
      case (k)
         4'd0:    p = 4'd0;
         4'd1:    p = 4'd1;
         4'd2:    p = 4'd4;
         4'd3:    p = 4'd8;
         4'd4:    p = 4'd5;
         4'd5:    p = 4'd2;
         4'd6:    p = 4'd3;
         4'd7:    p = 4'd6;
         4'd8:    p = 4'd9;
         4'd9:    p = 4'd12;
         4'd10:   p = 4'd13;
         4'd11:   p = 4'd10;
         4'd12:   p = 4'd7;
         4'd13:   p = 4'd11;
         4'd14:   p = 4'd14;
         default: p = 4'd15;
      endcase
      return p;
   endfunction

   // Bank storage: coefficients are never reset, QP and control are.
   logic signed [COEF_W-1:0] coef_q [2][16];
   logic [QP_W-1:0]          qp_q   [2];
   logic [QP_W-1:0]          qp_d   [2];
   logic [1:0]               full_q, full_d;
   logic                     wr_bank_q, wr_bank_d;
   logic [3:0]               wr_cnt_q, wr_cnt_d;
   logic                     rd_bank_q, rd_bank_d;
   logic [3:0]               rd_cnt_q, rd_cnt_d;

   logic in_fire, out_fire, wr_done, rd_done;
   logic [3:0] wr_pos;

   // Handshake decode; ready/valid depend only on registered flags.
   always_comb begin
      in_ready  = !full_q[wr_bank_q];
      out_valid = full_q[rd_bank_q];
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      wr_done   = in_fire && (wr_cnt_q == 4'd15);
      rd_done   = out_fire && (rd_cnt_q == 4'd15);
      wr_pos    = zz_pos(wr_cnt_q);
   end

   // Next-state: write and read sides act on different banks, so fill and drain completions compose.
   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_cnt_d  = wr_cnt_q;
      rd_bank_d = rd_bank_q;
      rd_cnt_d  = rd_cnt_q;
      full_d    = full_q;
      qp_d[0]   = qp_q[0];
      qp_d[1]   = qp_q[1];
      if (in_fire) begin
         wr_cnt_d = wr_cnt_q + 4'd1;
         if (wr_cnt_q == 4'd0) begin
            qp_d[wr_bank_q] = in_qp;
         end
         if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end
      end
      if (out_fire) begin
         rd_cnt_d = rd_cnt_q + 4'd1;
         if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end
      end
   end

   // Control and QP registers with synchronous reset; partial blocks are discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         wr_cnt_q  <= 4'd0;
         rd_bank_q <= 1'b0;
         rd_cnt_q  <= 4'd0;
         qp_q[0]   <= '0;
         qp_q[1]   <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_bank_q <= rd_bank_d;
         rd_cnt_q  <= rd_cnt_d;
         qp_q[0]   <= qp_d[0];
         qp_q[1]   <= qp_d[1];
      end
   end

   // Coefficient write: scatter each scan-order input to its raster slot.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         coef_q[wr_bank_q][wr_pos] <= in_coef;
      end
   end

   // Output mux: raster-order read of the draining bank, zero coefficient when nothing is full.
   always_comb begin
      out_coef = out_valid ? coef_q[rd_bank_q][rd_cnt_q] : '0;
      out_idx  = rd_cnt_q;
      out_qp   = qp_q[rd_bank_q];
      out_last = (rd_cnt_q == 4'd15);
   end

endmodule

// File: tb/tb_izigzag_4x4_buffer.sv
`timescale 1ns/1ps
// Purpose: randomized and directed checking of izigzag_4x4_buffer against a block-level reorder model.
// Latency: outputs sampled 1ns after each rising edge, inputs driven at the same point.
// Backpressure: random and directed out_ready / in_valid patterns, including both banks full.
module tb_izigzag_4x4_buffer;
   localparam int COEF_W = 16;
   localparam int QP_W   = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [COEF_W-1:0] in_coef;
   logic [QP_W-1:0]   in_qp;
   logic              out_valid;
   logic              out_ready;
   logic [COEF_W-1:0] out_coef;
   logic [3:0]        out_idx;
   logic [QP_W-1:0]   out_qp;
   logic              out_last;

   always #5 clk = ~clk;

   izigzag_4x4_buffer #(.COEF_W(COEF_W), .QP_W(QP_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coef   (in_coef),
      .in_qp     (in_qp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coef  (out_coef),
      .out_idx   (out_idx),
      .out_qp    (out_qp),
      .out_last  (out_last)
   );

   typedef struct {
      logic [COEF_W-1:0] coef;
      logic [3:0]        idx;
      logic [QP_W-1:0]   qp;
   } rec_t;

   // Reference model: completed blocks become 16 raster-ordered expected records.
   rec_t              exp_q[$];
   int                zz_tab [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
   logic [COEF_W-1:0] scan_buf [16];
   int                scan_n;
   int                full_cnt;
   logic [QP_W-1:0]   blk_qp, qp_next, qp_step;
   int                gen_mode;
   logic [COEF_W-1:0] cur_coef;
   int                n_checks, n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [COEF_W-1:0] gen();
      int r;
      if (gen_mode == 0) return COEF_W'(scan_n);
      r = int'($urandom_range(0, 7));
      if (r == 0) return 16'h8000;
      if (r == 1) return 16'h7fff;
      return COEF_W'($urandom);
   endfunction

   task automatic check_outputs();
      logic ev;
      ev = (full_cnt > 0);
      chk("in_ready", in_ready, full_cnt < 2);
      chk("out_valid", out_valid, ev);
      if (ev) begin
         chk("out_coef", out_coef, exp_q[0].coef);
         chk("out_idx", out_idx, exp_q[0].idx);
         chk("out_qp", out_qp, exp_q[0].qp);
         chk("out_last", out_last, exp_q[0].idx == 4'd15);
      end else begin
         chk("out_coef_empty", out_coef, 0);
      end
   endtask

   task automatic chk_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_coef", out_coef, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_qp", out_qp, 0);
      chk("rst_out_last", out_last, 0);
   endtask

   task automatic step(input logic iv, input logic orr, input logic rst);
      logic              in_acc, out_acc, drain_done;
      logic [COEF_W-1:0] raster [16];
      in_valid  = iv;
      in_coef   = cur_coef;
      in_qp     = (scan_n == 0) ? qp_next : QP_W'($urandom);
      out_ready = orr;
      reset     = rst;
      in_acc    = iv && (full_cnt < 2) && !rst;
      out_acc   = orr && (full_cnt > 0) && !rst;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         scan_n   = 0;
         full_cnt = 0;
         cur_coef = gen();
      end else begin
         drain_done = 1'b0;
         if (out_acc) begin
            drain_done = (exp_q[0].idx == 4'd15);
            void'(exp_q.pop_front());
         end
         if (in_acc) begin
            if (scan_n == 0) blk_qp = qp_next;
            scan_buf[scan_n] = cur_coef;
            scan_n++;
            if (scan_n == 16) begin
               for (int k = 0; k < 16; k++) raster[zz_tab[k]] = scan_buf[k];
               for (int p = 0; p < 16; p++) exp_q.push_back('{raster[p], 4'(p), blk_qp});
               full_cnt++;
               scan_n  = 0;
               qp_next = qp_next + qp_step;
            end
            cur_coef = gen();
         end
         if (drain_done) full_cnt--;
      end
   endtask

   task automatic run(input int n, input int iv_pct, input int or_pct);
      for (int i = 0; i < n; i++) begin
         check_outputs();
         step(int'($urandom_range(0, 99)) < iv_pct, int'($urandom_range(0, 99)) < or_pct, 1'b0);
      end
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      gen_mode = 0;
      scan_n   = 0;
      full_cnt = 0;
      cur_coef = '0;
      blk_qp   = '0;
      qp_next  = 6'd28;
      qp_step  = 6'd0;
      in_valid = 1'b0;
      in_coef  = '0;
      in_qp    = '0;
      out_ready = 1'b0;
      reset    = 1'b1;

      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      chk_reset();

      // Single block, values equal scan index, qp 28.
      run(16, 100, 100);
      run(20, 0, 100);

      // Four back-to-back blocks, qp 10/20/30/40.
      qp_next = 6'd10;
      qp_step = 6'd10;
      run(64, 100, 100);
      run(20, 0, 100);

      // Output stalled while three blocks are offered, then released.
      qp_next = 6'd5;
      qp_step = 6'd7;
      run(48, 100, 0);
      run(100, 100, 100);
      run(40, 0, 100);

      // Random gaps and backpressure with signed extremes.
      gen_mode = 1;
      cur_coef = gen();
      qp_step  = 6'd13;
      run(500, 70, 50);
      run(80, 0, 100);

      // Reset mid-operation: block A at out_idx 9, block B with 7 inputs.
      gen_mode = 0;
      step(1'b0, 1'b0, 1'b1);
      chk_reset();
      qp_next = 6'd33;
      run(16, 100, 0);
      run(7, 100, 0);
      run(9, 0, 100);
      chk("pre_reset_idx", out_idx, 9);
      step(1'b1, 1'b1, 1'b1);
      chk_reset();
      run(16, 100, 100);
      run(20, 0, 100);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
